// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes, FSM states
// and the predicate that separates counted shift/rotate modes from one-shot modes.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5,
    ASR  = 3'd6,
    CLR  = 3'd7
  } usr_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } usr_state_e;

  function automatic logic is_multistep(input usr_mode_e m);
    logic r;
    case (m)
      SHL, SHR, ROL, ROR, ASR: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usr_step_logic.sv
// Combinational next-state of the register for a single step of any mode.
// Used both for en-driven single steps and for each edge of a counted sequence.
module usr_step_logic
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next
);

  usr_mode_e mode_s;

  // Decode the mode into the register value after one step.
  always_comb begin
    mode_s = usr_mode_e'(mode);
    q_next = q;
    case (mode_s)
      HOLD:    q_next = q;
      LOAD:    q_next = d;
      SHL:     q_next = {q[WIDTH-2:0], sin_r};
      SHR:     q_next = {sin_l, q[WIDTH-1:1]};
      ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      ROR:     q_next = {q[0], q[WIDTH-1:1]};
      ASR:     q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      CLR:     q_next = {WIDTH{1'b0}};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: single-step ops on en, counted
// shift/rotate sequences on start with a busy/done handshake.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  usr_state_e       state_r;
  usr_mode_e        mode_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] q_r;
  logic             busy_r;
  logic             done_r;

  usr_mode_e        mode_in_s;
  logic [2:0]       step_mode_s;
  logic [WIDTH-1:0] q_next_s;

  // While sequencing, the step logic follows the latched mode, not the live input.
  always_comb begin
    mode_in_s = usr_mode_e'(mode);
    if (state_r == SHIFT) begin
      step_mode_s = mode_r;
    end else begin
      step_mode_s = mode;
    end
  end

  usr_step_logic #(
    .WIDTH (WIDTH)
  ) u_step (
    .q      (q_r),
    .mode   (step_mode_s),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .d      (d),
    .q_next (q_next_s)
  );

  // Register, counter and IDLE/SHIFT control with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      mode_r  <= HOLD;
      cnt_r   <= {CNT_W{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (is_multistep(mode_in_s) && (amount != {CNT_W{1'b0}})) begin
              mode_r  <= mode_in_s;
              cnt_r   <= amount;
              busy_r  <= 1'b1;
              state_r <= SHIFT;
            end else begin
              // A zero-length shift request completes without touching q.
              if (!is_multistep(mode_in_s)) begin
                q_r <= q_next_s;
              end else begin
                q_r <= q_r;
              end
              done_r <= 1'b1;
            end
          end else if (en) begin
            q_r <= q_next_s;
          end else begin
            q_r <= q_r;
          end
        end
        SHIFT: begin
          q_r   <= q_next_s;
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else begin
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign q      = q_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign sout_l = q_r[WIDTH-1];
  assign sout_r = q_r[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register at WIDTH=8.
module tb_universal_shift_register;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  int vectors;
  int miscompares;
  int done_cnt;

  universal_shift_register #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // q plus both serial outputs, derived from the expected q value.
  task automatic chk_q(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    e = exp;
    chk({tag, ".q"}, {24'd0, q}, {24'd0, e});
    chk({tag, ".sout_l"}, {31'd0, sout_l}, {31'd0, e[7]});
    chk({tag, ".sout_r"}, {31'd0, sout_r}, {31'd0, e[0]});
  endtask

  task automatic chk_hs(input string tag, input logic exp_busy, input logic exp_done);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    en     = 1'b0;
    start  = 1'b0;
    mode   = 3'd0;
    amount = 4'd0;
    d      = 8'h00;
    sin_l  = 1'b0;
    sin_r  = 1'b0;

    tick();
    chk_q("reset", 8'h00);
    chk_hs("reset", 1'b0, 1'b0);
    rst = 1'b0;

    // Single-step operations
    en = 1'b1; mode = 3'd1; d = 8'h81;
    tick(); chk_q("en_load", 8'h81); chk_hs("en_load", 1'b0, 1'b0);
    mode = 3'd4;
    tick(); chk_q("en_rol", 8'h03); chk_hs("en_rol", 1'b0, 1'b0);
    mode = 3'd1; d = 8'h80;
    tick(); chk_q("en_load80", 8'h80);
    mode = 3'd6;
    tick(); chk_q("en_asr", 8'hC0); chk_hs("en_asr", 1'b0, 1'b0);
    mode = 3'd7;
    tick(); chk_q("en_clr", 8'h00); chk_hs("en_clr", 1'b0, 1'b0);
    en = 1'b0;
    tick(); chk_q("idle_hold", 8'h00);

    // Multi-step SHL by 3 with sin_r=1
    en = 1'b1; mode = 3'd1; d = 8'h81;
    tick(); en = 1'b0;
    start = 1'b1; mode = 3'd2; amount = 4'd3; sin_r = 1'b1;
    tick(); start = 1'b0;
    chk_q("shl_acc", 8'h81); chk_hs("shl_acc", 1'b1, 1'b0);
    tick(); chk_q("shl_s1", 8'h03); chk_hs("shl_s1", 1'b1, 1'b0);
    tick(); chk_q("shl_s2", 8'h07); chk_hs("shl_s2", 1'b1, 1'b0);
    tick(); chk_q("shl_s3", 8'h0F); chk_hs("shl_s3", 1'b0, 1'b1);
    tick(); chk_hs("shl_post", 1'b0, 1'b0);
    sin_r = 1'b0;

    // ROR by 8 with noise on ignored inputs
    en = 1'b1; mode = 3'd1; d = 8'hA5;
    tick(); en = 1'b0;
    start = 1'b1; mode = 3'd5; amount = 4'd8;
    tick();
    chk_hs("ror_acc", 1'b1, 1'b0);
    done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      en = i[0]; start = ~i[0]; mode = 3'(i); d = 8'(i * 17); amount = 4'(i);
      tick();
      if (done) done_cnt++;
      if (i == 4) chk_q("ror_mid", 8'h5A);
    end
    chk_q("ror_end", 8'hA5); chk_hs("ror_end", 1'b0, 1'b1);
    en = 1'b0; start = 1'b0; mode = 3'd0;
    tick();
    if (done) done_cnt++;
    chk("ror_done_pulses", 32'(done_cnt), 32'd1);
    chk_q("ror_after", 8'hA5);

    // Immediate start ops
    start = 1'b1; mode = 3'd1; d = 8'h3C;
    tick(); start = 1'b0;
    chk_q("st_load", 8'h3C); chk_hs("st_load", 1'b0, 1'b1);
    tick(); chk_hs("st_load_post", 1'b0, 1'b0);
    start = 1'b1; mode = 3'd2; amount = 4'd0; sin_r = 1'b1;
    tick(); start = 1'b0;
    chk_q("st_shl0", 8'h3C); chk_hs("st_shl0", 1'b0, 1'b1);
    tick(); chk_hs("st_shl0_post", 1'b0, 1'b0); chk_q("st_shl0_post", 8'h3C);
    start = 1'b1; mode = 3'd7;
    tick(); start = 1'b0;
    chk_q("st_clr", 8'h00); chk_hs("st_clr", 1'b0, 1'b1);
    sin_r = 1'b0;

    // Overlong ROL by 15, then back-to-back start in the done cycle
    en = 1'b1; mode = 3'd1; d = 8'h01;
    tick(); en = 1'b0;
    start = 1'b1; mode = 3'd4; amount = 4'd15;
    tick(); start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk_q("rol15", 8'h80); chk_hs("rol15", 1'b0, 1'b1);
    start = 1'b1; mode = 3'd2; amount = 4'd2; sin_r = 1'b0;
    tick(); start = 1'b0;
    chk_q("b2b_acc", 8'h80); chk_hs("b2b_acc", 1'b1, 1'b0);
    tick(); chk_q("b2b_s1", 8'h00);
    tick(); chk_q("b2b_s2", 8'h00); chk_hs("b2b_s2", 1'b0, 1'b1);

    // Reset in the middle of SHR by 6
    en = 1'b1; mode = 3'd1; d = 8'hFF;
    tick(); en = 1'b0;
    start = 1'b1; mode = 3'd3; amount = 4'd6; sin_l = 1'b0;
    tick(); start = 1'b0;
    tick(); chk_q("rst_s1", 8'h7F);
    tick(); chk_q("rst_s2", 8'h3F); chk_hs("rst_s2", 1'b1, 1'b0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk_q("rst_mid", 8'h00); chk_hs("rst_mid", 1'b0, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    chk_q("rst_quiet", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
